// File: rtl/counter_pkg.sv
// Shared definitions for the range counter family: mode constants and the
// bound-clamping helper used by both the load path and reference models.
package counter_pkg;

    localparam int unsigned CNT_WRAP = 0;
    localparam int unsigned CNT_SAT  = 1;

    // Force value into the inclusive range [lo, hi] (unsigned compare).
    function automatic int unsigned clamp(input int unsigned value,
                                          input int unsigned lo,
                                          input int unsigned hi);
        if (value < lo) begin
            return lo;
        end
        if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/range_counter_next.sv
// Combinational next-state logic for range_counter: load clamping,
// up/down stepping, and wrap/saturate handling at the range bounds.
module range_counter_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MIN      = 1,
    parameter int unsigned MAX      = 12,
    parameter int unsigned SATURATE = CNT_WRAP
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_en,
    input  logic             i_load,
    input  logic             i_up,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q_next,
    output logic             o_wrap_evt
);

    localparam logic [WIDTH:0]   L_MIN = (WIDTH+1)'(MIN);
    localparam logic [WIDTH:0]   L_MAX = (WIDTH+1)'(MAX);
    localparam logic [WIDTH-1:0] Q_MIN = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MAX);

    logic [WIDTH:0]   w_q_ext;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH-1:0] w_dec;

    // Increment is one bit wider so q == 2^WIDTH-1 cannot alias to zero
    // when compared against MAX.
    always_comb begin
        w_q_ext = {1'b0, i_q};
        w_inc   = w_q_ext + (WIDTH+1)'(1);
        w_dec   = i_q - WIDTH'(1);
    end

    // Priority load > count > hold; wrap event only on a bound crossing in wrap mode.
    always_comb begin
        o_q_next   = i_q;
        o_wrap_evt = 1'b0;
        if (i_load) begin
            o_q_next = WIDTH'(clamp(32'(i_d), MIN, MAX));
        end else if (i_en) begin
            if (i_up) begin
                if (w_inc <= L_MAX) begin
                    o_q_next = w_inc[WIDTH-1:0];
                end else if (SATURATE == CNT_WRAP) begin
                    o_q_next   = Q_MIN;
                    o_wrap_evt = 1'b1;
                end
            end else begin
                if (w_q_ext > L_MIN) begin
                    o_q_next = w_dec;
                end else if (SATURATE == CNT_WRAP) begin
                    o_q_next   = Q_MAX;
                    o_wrap_evt = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/range_counter.sv
// Parametrised modulo counter over [MIN, MAX] with up/down, synchronous
// load, wrap or saturate mode, terminal count and a registered wrap pulse.
module range_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MIN      = 1,
    parameter int unsigned MAX      = 12,
    parameter int unsigned SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrapped
);

    localparam bit CFG_OK = (WIDTH >= 1) && (MIN <= MAX) && (SATURATE <= CNT_SAT) &&
                            ((WIDTH >= 32) || ((MAX >> WIDTH) == 0));

    if (!CFG_OK) begin : g_cfg_check
        $fatal(1, "range_counter: illegal WIDTH/MIN/MAX/SATURATE combination");
    end

    localparam logic [WIDTH-1:0] Q_MIN = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MAX);

    logic [WIDTH-1:0] r_q;
    logic             r_wrapped;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_evt;

    range_counter_next #(
        .WIDTH    (WIDTH),
        .MIN      (MIN),
        .MAX      (MAX),
        .SATURATE (SATURATE)
    ) u_next (
        .i_q        (r_q),
        .i_en       (en),
        .i_load     (load),
        .i_up       (up),
        .i_d        (d),
        .o_q_next   (w_q_next),
        .o_wrap_evt (w_wrap_evt)
    );

    // Count and wrap-pulse registers; reset overrides load and enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q       <= Q_MIN;
            r_wrapped <= 1'b0;
        end else begin
            r_q       <= w_q_next;
            r_wrapped <= w_wrap_evt;
        end
    end

    // Terminal count flags the bound in the current direction of travel.
    always_comb begin
        tc = en & (up ? (r_q == Q_MAX) : (r_q == Q_MIN));
    end

    assign q       = r_q;
    assign wrapped = r_wrapped;

endmodule

// File: tb/tb_range_counter.sv
// Self-checking bench for range_counter: three instances (1..12 wrap,
// 1..12 saturate, 0..15 wrap) driven by directed steps then random stimulus,
// each compared every cycle against an arithmetic reference model.
module tb_range_counter;
    import counter_pkg::*;

    localparam int unsigned NDUT = 3;
    localparam int unsigned PMIN [NDUT] = '{1, 1, 0};
    localparam int unsigned PMAX [NDUT] = '{12, 12, 15};
    localparam int unsigned PSAT [NDUT] = '{0, 1, 0};

    logic       clk;
    logic       rst_v [NDUT];
    logic       en_v  [NDUT];
    logic       ld_v  [NDUT];
    logic       up_v  [NDUT];
    logic [3:0] d_v   [NDUT];
    logic [3:0] q_v   [NDUT];
    logic       tc_v  [NDUT];
    logic       wr_v  [NDUT];

    int unsigned mq [NDUT];
    bit          mw [NDUT];

    int n_tests;
    int n_fail;

    range_counter #(.WIDTH(4), .MIN(1), .MAX(12), .SATURATE(CNT_WRAP)) u_wrap (
        .clk(clk), .reset(rst_v[0]), .en(en_v[0]), .load(ld_v[0]), .up(up_v[0]),
        .d(d_v[0]), .q(q_v[0]), .tc(tc_v[0]), .wrapped(wr_v[0])
    );

    range_counter #(.WIDTH(4), .MIN(1), .MAX(12), .SATURATE(CNT_SAT)) u_sat (
        .clk(clk), .reset(rst_v[1]), .en(en_v[1]), .load(ld_v[1]), .up(up_v[1]),
        .d(d_v[1]), .q(q_v[1]), .tc(tc_v[1]), .wrapped(wr_v[1])
    );

    range_counter #(.WIDTH(4), .MIN(0), .MAX(15), .SATURATE(CNT_WRAP)) u_full (
        .clk(clk), .reset(rst_v[2]), .en(en_v[2]), .load(ld_v[2]), .up(up_v[2]),
        .d(d_v[2]), .q(q_v[2]), .tc(tc_v[2]), .wrapped(wr_v[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int idx,
                         input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
        end
    endtask

    // Reference: counting is an offset within a span of (MAX-MIN+1) values,
    // advanced modulo the span in wrap mode or clipped in saturate mode.
    task automatic model_edge();
        for (int i = 0; i < NDUT; i++) begin
            int unsigned span;
            int unsigned off;
            if (rst_v[i]) begin
                mq[i] = PMIN[i];
                mw[i] = 1'b0;
            end else if (ld_v[i]) begin
                mq[i] = clamp(32'(d_v[i]), PMIN[i], PMAX[i]);
                mw[i] = 1'b0;
            end else if (en_v[i]) begin
                if (PSAT[i] != 0) begin
                    if (up_v[i]) mq[i] = (mq[i] < PMAX[i]) ? mq[i] + 1 : PMAX[i];
                    else         mq[i] = (mq[i] > PMIN[i]) ? mq[i] - 1 : PMIN[i];
                    mw[i] = 1'b0;
                end else begin
                    span  = PMAX[i] - PMIN[i] + 1;
                    off   = mq[i] - PMIN[i];
                    mw[i] = up_v[i] ? (mq[i] == PMAX[i]) : (mq[i] == PMIN[i]);
                    off   = up_v[i] ? (off + 1) % span : (off + span - 1) % span;
                    mq[i] = PMIN[i] + off;
                end
            end else begin
                mw[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NDUT; i++) begin
            bit tc_exp;
            tc_exp = en_v[i] && (up_v[i] ? (mq[i] == PMAX[i]) : (mq[i] == PMIN[i]));
            check("q", i, 32'(q_v[i]), mq[i]);
            check("wrapped", i, 32'(wr_v[i]), 32'(mw[i]));
            check("tc", i, 32'(tc_v[i]), 32'(tc_exp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < NDUT; i++) begin
            rst_v[i] = 1'b1; en_v[i] = 1'b0; ld_v[i] = 1'b0; up_v[i] = 1'b1; d_v[i] = '0;
            mq[i] = PMIN[i]; mw[i] = 1'b0;
        end

        // Reset state
        step();
        step();
        check("rst_q_wrap", 0, 32'(q_v[0]), 1);
        check("rst_q_full", 2, 32'(q_v[2]), 0);

        // Up-count through the wrap (1..12 then back to 1)
        rst_v[0] = 1'b0; en_v[0] = 1'b1; up_v[0] = 1'b1;
        repeat (11) step();
        check("up_at_max_q", 0, 32'(q_v[0]), 12);
        check("up_at_max_tc", 0, 32'(tc_v[0]), 1);
        step();
        check("up_wrap_q", 0, 32'(q_v[0]), 1);
        check("up_wrap_pulse", 0, 32'(wr_v[0]), 1);
        step();
        check("up_after_wrap_q", 0, 32'(q_v[0]), 2);
        check("up_after_wrap_pulse", 0, 32'(wr_v[0]), 0);
        repeat (10) step();
        step();
        check("up_rewrap_q", 0, 32'(q_v[0]), 1);

        // Down-count from 1 wraps to 12
        up_v[0] = 1'b0;
        #1;
        check("down_tc_at_min", 0, 32'(tc_v[0]), 1);
        step();
        check("down_wrap_q", 0, 32'(q_v[0]), 12);
        check("down_wrap_pulse", 0, 32'(wr_v[0]), 1);
        step();
        step();
        check("down_q10", 0, 32'(q_v[0]), 10);

        // Loads: in range, clamped high, clamped low, with en=0
        ld_v[0] = 1'b1; en_v[0] = 1'b0; d_v[0] = 4'd5;
        step();
        check("load5", 0, 32'(q_v[0]), 5);
        en_v[0] = 1'b1; d_v[0] = 4'd9;
        step();
        check("load9_over_en", 0, 32'(q_v[0]), 9);
        ld_v[0] = 1'b0; up_v[0] = 1'b1;
        step();
        check("count_after_load", 0, 32'(q_v[0]), 10);
        ld_v[0] = 1'b1; d_v[0] = 4'd15;
        step();
        check("load_clamp_hi", 0, 32'(q_v[0]), 12);
        d_v[0] = 4'd0;
        step();
        check("load_clamp_lo", 0, 32'(q_v[0]), 1);
        en_v[0] = 1'b0; d_v[0] = 4'd7;
        step();
        check("load7_no_en", 0, 32'(q_v[0]), 7);

        // Reset beats simultaneous load and enable
        rst_v[0] = 1'b1; ld_v[0] = 1'b1; en_v[0] = 1'b1; d_v[0] = 4'd3;
        step();
        check("rst_prio_q", 0, 32'(q_v[0]), 1);
        check("rst_prio_wr", 0, 32'(wr_v[0]), 0);
        rst_v[0] = 1'b0; ld_v[0] = 1'b0; up_v[0] = 1'b1;
        step();
        check("rst_release_q", 0, 32'(q_v[0]), 2);

        // Saturate instance holds at MAX
        rst_v[1] = 1'b0; ld_v[1] = 1'b1; d_v[1] = 4'd10;
        step();
        ld_v[1] = 1'b0; en_v[1] = 1'b1; up_v[1] = 1'b1;
        step();
        check("sat_q11", 1, 32'(q_v[1]), 11);
        step();
        step();
        step();
        check("sat_hold_q", 1, 32'(q_v[1]), 12);
        check("sat_hold_tc", 1, 32'(tc_v[1]), 1);
        check("sat_no_wrap", 1, 32'(wr_v[1]), 0);
        up_v[1] = 1'b0;
        step();
        check("sat_down_q", 1, 32'(q_v[1]), 11);

        // Full-range instance crosses 15 -> 0
        rst_v[2] = 1'b0; ld_v[2] = 1'b1; d_v[2] = 4'd14;
        step();
        ld_v[2] = 1'b0; en_v[2] = 1'b1; up_v[2] = 1'b1;
        step();
        check("full_q15", 2, 32'(q_v[2]), 15);
        step();
        check("full_wrap_q", 2, 32'(q_v[2]), 0);
        check("full_wrap_pulse", 2, 32'(wr_v[2]), 1);
        en_v[2] = 1'b0;
        repeat (3) step();
        check("full_hold_q", 2, 32'(q_v[2]), 0);
        check("full_hold_tc", 2, 32'(tc_v[2]), 0);

        // Random mixed traffic on all instances
        repeat (400) begin
            for (int i = 0; i < NDUT; i++) begin
                rst_v[i] = ($urandom_range(0, 31) == 0);
                ld_v[i]  = ($urandom_range(0, 5) == 0);
                en_v[i]  = ($urandom_range(0, 3) != 0);
                up_v[i]  = ($urandom_range(0, 2) != 0);
                d_v[i]   = 4'($urandom_range(0, 15));
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
